// File: rtl/rsp_s1_prep_diff_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rsp_s1_prep_diff_gen
//  Purpose  : Burst-parallel lag-difference stage, y[n] = x[n] - x[n-LAG],
//             with per-frame config latch, seeding and symmetric saturation.
//  Revision : 1.0
// ============================================================================
module rsp_s1_prep_diff_gen #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LANES        = 8,
    parameter int MAX_LAG      = 4,
    parameter int DATA_NUM     = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_wide,
    input  logic [$clog2(MAX_LAG+1)-1:0]    i_lag,
    input  logic [LANES*SAMPLE_WIDTH-1:0]   i_x_data,
    input  logic                            i_x_valid,
    input  logic                            i_x_last,
    output logic [LANES*SAMPLE_WIDTH-1:0]   o_y_data,
    output logic                            o_y_valid,
    output logic                            o_y_last,
    output logic                            o_sat,
    output logic                            o_frame_err
);
    localparam int c_W     = SAMPLE_WIDTH;
    localparam int c_NW    = LANES / 2;
    localparam int c_HL    = 2 * MAX_LAG;
    localparam int c_LAG_W = $clog2(MAX_LAG + 1);
    localparam int c_CNT_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [c_W-1:0]   c_MAX_N = {1'b0, {(c_W-1){1'b1}}};
    localparam logic [c_W-1:0]   c_MIN_N = {1'b1, {(c_W-2){1'b0}}, 1'b1};
    localparam logic [2*c_W-1:0] c_MAX_W = {1'b0, {(2*c_W-1){1'b1}}};
    localparam logic [2*c_W-1:0] c_MIN_W = {1'b1, {(2*c_W-2){1'b0}}, 1'b1};

    logic                      r_in_frame;
    logic                      r_wide;
    logic [c_LAG_W-1:0]        r_lag;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_HL*c_W-1:0]       r_hist;

    logic                      r_s1_valid, r_s1_last, r_s1_err, r_s1_wide;
    logic [LANES*(c_W+1)-1:0]  r_s1_dn;
    logic [c_NW*(2*c_W+1)-1:0] r_s1_dw;

    logic                      w_start, w_wide, w_cnt_end, w_close, w_err;
    logic [c_LAG_W-1:0]        w_lag_in, w_lag;

    assign w_start   = !r_in_frame;
    assign w_lag_in  = (i_lag == '0 || i_lag > c_LAG_W'(MAX_LAG)) ? c_LAG_W'(1) : i_lag;
    assign w_wide    = w_start ? i_wide : r_wide;
    assign w_lag     = w_start ? w_lag_in : r_lag;
    assign w_cnt_end = (r_cnt == c_CNT_W'(DATA_NUM - 1));
    assign w_close   = i_x_last | w_cnt_end;
    assign w_err     = i_x_last ^ w_cnt_end;

    // History holds the last 2*MAX_LAG lanes: MAX_LAG narrow or MAX_LAG wide samples.
    logic [c_W-1:0]            w_en [MAX_LAG+LANES];
    logic [2*c_W-1:0]          w_ew [MAX_LAG+c_NW];
    logic [c_W-1:0]            w_pn [LANES];
    logic [2*c_W-1:0]          w_pw [c_NW];
    logic [LANES*(c_W+1)-1:0]  w_dn;
    logic [c_NW*(2*c_W+1)-1:0] w_dw;

    always_comb begin
        for (int j = 0; j < MAX_LAG; j++) begin
            w_en[j] = r_hist[(MAX_LAG+j)*c_W +: c_W];
            w_ew[j] = r_hist[2*j*c_W +: 2*c_W];
        end
        for (int n = 0; n < LANES; n++) w_en[MAX_LAG+n] = i_x_data[n*c_W +: c_W];
        for (int n = 0; n < c_NW; n++)  w_ew[MAX_LAG+n] = i_x_data[2*n*c_W +: 2*c_W];
        w_dn = '0;
        w_dw = '0;
        // Defaulting the lagged operand to the sample itself zeroes the first LAG outputs of a frame.
        for (int n = 0; n < LANES; n++) begin
            w_pn[n] = w_en[MAX_LAG+n];
            for (int l = 1; l <= MAX_LAG; l++) begin
                if (w_lag == c_LAG_W'(l) && !(w_start && n < l)) w_pn[n] = w_en[MAX_LAG+n-l];
            end
            w_dn[n*(c_W+1) +: c_W+1] = {w_en[MAX_LAG+n][c_W-1], w_en[MAX_LAG+n]}
                                     - {w_pn[n][c_W-1], w_pn[n]};
        end
        for (int n = 0; n < c_NW; n++) begin
            w_pw[n] = w_ew[MAX_LAG+n];
            for (int l = 1; l <= MAX_LAG; l++) begin
                if (w_lag == c_LAG_W'(l) && !(w_start && n < l)) w_pw[n] = w_ew[MAX_LAG+n-l];
            end
            w_dw[n*(2*c_W+1) +: 2*c_W+1] = {w_ew[MAX_LAG+n][2*c_W-1], w_ew[MAX_LAG+n]}
                                         - {w_pw[n][2*c_W-1], w_pw[n]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_frame <= 1'b0;
            r_wide     <= 1'b0;
            r_lag      <= c_LAG_W'(1);
            r_cnt      <= '0;
            r_hist     <= '0;
        end else if (i_x_valid) begin
            r_wide <= w_wide;
            r_lag  <= w_lag;
            r_hist <= i_x_data[LANES*c_W-1 -: c_HL*c_W];
            if (w_close) begin
                r_cnt      <= '0;
                r_in_frame <= 1'b0;
            end else begin
                r_cnt      <= r_cnt + c_CNT_W'(1);
                r_in_frame <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_wide  <= 1'b0;
            r_s1_dn    <= '0;
            r_s1_dw    <= '0;
        end else begin
            r_s1_valid <= i_x_valid;
            r_s1_last  <= i_x_valid & w_close;
            r_s1_err   <= i_x_valid & w_err;
            if (i_x_valid) begin
                r_s1_wide <= w_wide;
                r_s1_dn   <= w_dn;
                r_s1_dw   <= w_dw;
            end
        end
    end

    // Clamp range is symmetric: -2^(S-1) is pulled in to -(2^(S-1)-1).
    logic [LANES*c_W-1:0] w_yn, w_yw;
    logic                 w_sat_n, w_sat_w;

    always_comb begin
        w_yn    = '0;
        w_yw    = '0;
        w_sat_n = 1'b0;
        w_sat_w = 1'b0;
        for (int n = 0; n < LANES; n++) begin
            if (!r_s1_dn[n*(c_W+1)+c_W] && r_s1_dn[n*(c_W+1)+c_W-1]) begin
                w_yn[n*c_W +: c_W] = c_MAX_N;
                w_sat_n            = 1'b1;
            end else if (r_s1_dn[n*(c_W+1)+c_W] && (!r_s1_dn[n*(c_W+1)+c_W-1]
                         || r_s1_dn[n*(c_W+1) +: c_W-1] == '0)) begin
                w_yn[n*c_W +: c_W] = c_MIN_N;
                w_sat_n            = 1'b1;
            end else begin
                w_yn[n*c_W +: c_W] = r_s1_dn[n*(c_W+1) +: c_W];
            end
        end
        for (int n = 0; n < c_NW; n++) begin
            if (!r_s1_dw[n*(2*c_W+1)+2*c_W] && r_s1_dw[n*(2*c_W+1)+2*c_W-1]) begin
                w_yw[2*n*c_W +: 2*c_W] = c_MAX_W;
                w_sat_w                = 1'b1;
            end else if (r_s1_dw[n*(2*c_W+1)+2*c_W] && (!r_s1_dw[n*(2*c_W+1)+2*c_W-1]
                         || r_s1_dw[n*(2*c_W+1) +: 2*c_W-1] == '0)) begin
                w_yw[2*n*c_W +: 2*c_W] = c_MIN_W;
                w_sat_w                = 1'b1;
            end else begin
                w_yw[2*n*c_W +: 2*c_W] = r_s1_dw[n*(2*c_W+1) +: 2*c_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_y_data    <= '0;
            o_y_valid   <= 1'b0;
            o_y_last    <= 1'b0;
            o_sat       <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_y_valid   <= r_s1_valid;
            o_y_last    <= r_s1_valid & r_s1_last;
            o_frame_err <= r_s1_valid & r_s1_err;
            o_sat       <= r_s1_valid & (r_s1_wide ? w_sat_w : w_sat_n);
            if (r_s1_valid) o_y_data <= r_s1_wide ? w_yw : w_yn;
        end
    end
endmodule
`default_nettype wire
